ppu_cpu_regs: RTL and testbench

- CPU-facing register front end of the PPU core. Decodes CPU accesses to $2000-$2007 (selected by CPUA) and holds PPUCTL, PPUMASK, status, OAMADDR, scroll and the VRAM address/read buffer.
- Drives the VRAM and OAM write/read ports that the renderer's memories expose, and generates NMI from the vblank flag.
- Sits directly upstream of the PPU core, which consumes its control registers and memory writes.

---
 rtl/ppu_cpu_regs_if.sv | 11 +
 rtl/ppu_cpu_regs.sv | 153 +++++++++++++++
 tb/tb_ppu_cpu_regs.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_cpu_regs_if.sv
// rtl/ppu_cpu_regs_if.sv - CPU register bus between the CPU side and the PPU register front end
interface ppu_cpu_regs_if;
    logic       CS;
    logic       RW;
    logic [2:0] CPUA;
    logic [7:0] CPUDI;
    logic [7:0] CPUDO;

    modport master (output CS, output RW, output CPUA, output CPUDI, input CPUDO);
    modport slave  (input CS, input RW, input CPUA, input CPUDI, output CPUDO);
endinterface

// File: rtl/ppu_cpu_regs.sv
// rtl/ppu_cpu_regs.sv - PPU CPU register front end ($2000-$2007), VRAM/OAM ports and NMI
// Optional unbuffered palette reads via PPU_PALETTE_READ_BYPASS_EN.
module ppu_cpu_regs #(
    parameter int                 VRAM_AW  = 14,
    parameter logic [VRAM_AW-1:0] PAL_BASE = VRAM_AW'('h3F00)
) (
    input  logic               PPU_SLOW_CLOCK,
    input  logic               RST,
    ppu_cpu_regs_if.slave      cpu,
    output logic               NMI,
    input  logic               VBL_SET,
    input  logic               VBL_CLR,
    input  logic               SPR0_SET,
    output logic [7:0]         PPUCTL_O,
    output logic [7:0]         PPUMASK_O,
    output logic [7:0]         SCROLL_X,
    output logic [7:0]         SCROLL_Y,
    output logic [VRAM_AW-1:0] VRAM_ADDR,
    output logic [7:0]         VRAM_WDATA,
    output logic               VRAM_WE,
    output logic               VRAM_RE,
    input  logic [7:0]         VRAM_RDATA,
    output logic [7:0]         OAM_ADDR,
    output logic [7:0]         OAM_WDATA,
    output logic               OAM_WE,
    input  logic [7:0]         OAM_RDATA
);

`ifdef PPU_PALETTE_READ_BYPASS_EN
    localparam bit PAL_BYPASS = 1'b1;
`else
    localparam bit PAL_BYPASS = 1'b0;
`endif

    logic               cs_q;
    logic               access;
    logic               rd_acc;
    logic               wr_acc;
    logic               status_rd;
    logic [13:0]        t;
    logic [13:0]        t_full;
    logic               w;
    logic [7:0]         rbuf;
    logic [7:0]         open_bus;
    logic               vbl;
    logic               spr0;
    logic [7:0]         status_byte;
    logic [VRAM_AW-1:0] vram_inc;

    assign access      = cpu.CS & ~cs_q;
    assign rd_acc      = access & cpu.RW;
    assign wr_acc      = access & ~cpu.RW;
    assign status_rd   = rd_acc && (cpu.CPUA == 3'd2);
    // A vblank edge landing on the status read is hidden from that read and then lost.
    assign status_byte = {vbl & ~VBL_SET, spr0, 1'b0, open_bus[4:0]};
    assign t_full      = {t[13:8], cpu.CPUDI};
    assign vram_inc    = PPUCTL_O[2] ? VRAM_AW'(32) : VRAM_AW'(1);

    always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
        if (RST) begin
            // cs_q resets high so a CS held through reset is not taken as a new access.
            cs_q       <= 1'b1;
            cpu.CPUDO  <= 8'h00;
            NMI        <= 1'b0;
            PPUCTL_O   <= 8'h00;
            PPUMASK_O  <= 8'h00;
            SCROLL_X   <= 8'h00;
            SCROLL_Y   <= 8'h00;
            VRAM_ADDR  <= '0;
            VRAM_WDATA <= 8'h00;
            VRAM_WE    <= 1'b0;
            VRAM_RE    <= 1'b0;
            OAM_ADDR   <= 8'h00;
            OAM_WDATA  <= 8'h00;
            OAM_WE     <= 1'b0;
            t          <= 14'h0000;
            w          <= 1'b0;
            rbuf       <= 8'h00;
            open_bus   <= 8'h00;
            vbl        <= 1'b0;
            spr0       <= 1'b0;
        end else begin
            cs_q    <= cpu.CS;
            VRAM_WE <= 1'b0;
            VRAM_RE <= 1'b0;
            OAM_WE  <= 1'b0;
            NMI     <= vbl & PPUCTL_O[7];

            if (VBL_CLR)        vbl <= 1'b0;
            else if (status_rd) vbl <= 1'b0;
            else if (VBL_SET)   vbl <= 1'b1;

            if (VBL_CLR)       spr0 <= 1'b0;
            else if (SPR0_SET) spr0 <= 1'b1;

            // Second half of a $2007/$2004 access: post-increment and buffer fill.
            if (VRAM_WE || VRAM_RE) VRAM_ADDR <= VRAM_ADDR + vram_inc;
            if (VRAM_RE) begin
                rbuf <= VRAM_RDATA;
                if (PAL_BYPASS && (VRAM_ADDR >= PAL_BASE)) cpu.CPUDO <= VRAM_RDATA;
            end
            if (OAM_WE) OAM_ADDR <= OAM_ADDR + 8'd1;

            if (wr_acc) begin
                open_bus <= cpu.CPUDI;
                case (cpu.CPUA)
                    3'd0: PPUCTL_O  <= cpu.CPUDI;
                    3'd1: PPUMASK_O <= cpu.CPUDI;
                    3'd3: OAM_ADDR  <= cpu.CPUDI;
                    3'd4: begin
                        OAM_WE    <= 1'b1;
                        OAM_WDATA <= cpu.CPUDI;
                    end
                    3'd5: begin
                        if (!w) SCROLL_X <= cpu.CPUDI;
                        else    SCROLL_Y <= cpu.CPUDI;
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) begin
                            t[13:8] <= cpu.CPUDI[5:0];
                        end else begin
                            t[7:0]    <= cpu.CPUDI;
                            VRAM_ADDR <= t_full[VRAM_AW-1:0];
                        end
                        w <= ~w;
                    end
                    3'd7: begin
                        VRAM_WE    <= 1'b1;
                        VRAM_WDATA <= cpu.CPUDI;
                    end
                    default: ;
                endcase
            end

            if (rd_acc) begin
                case (cpu.CPUA)
                    3'd2: begin
                        cpu.CPUDO <= status_byte;
                        w         <= 1'b0;
                    end
                    3'd4: cpu.CPUDO <= OAM_RDATA;
                    3'd7: begin
                        cpu.CPUDO <= rbuf;
                        VRAM_RE   <= 1'b1;
                    end
                    default: cpu.CPUDO <= open_bus;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// tb/tb_ppu_cpu_regs.sv - scoreboard bench for ppu_cpu_regs with a register-level reference model
module tb_ppu_cpu_regs;
    localparam logic [13:0] PAL_BASE = 14'h3F00;

    logic        PPU_SLOW_CLOCK = 1'b0;
    logic        RST;
    logic        NMI, VBL_SET, VBL_CLR, SPR0_SET;
    logic [7:0]  PPUCTL_O, PPUMASK_O, SCROLL_X, SCROLL_Y;
    logic [13:0] VRAM_ADDR;
    logic [7:0]  VRAM_WDATA, VRAM_RDATA, OAM_ADDR, OAM_WDATA, OAM_RDATA;
    logic        VRAM_WE, VRAM_RE, OAM_WE;

    always #5 PPU_SLOW_CLOCK = ~PPU_SLOW_CLOCK;

    ppu_cpu_regs_if cpu();

    ppu_cpu_regs #(.VRAM_AW(14), .PAL_BASE(PAL_BASE)) dut (
        .PPU_SLOW_CLOCK(PPU_SLOW_CLOCK), .RST(RST), .cpu(cpu), .NMI(NMI),
        .VBL_SET(VBL_SET), .VBL_CLR(VBL_CLR), .SPR0_SET(SPR0_SET),
        .PPUCTL_O(PPUCTL_O), .PPUMASK_O(PPUMASK_O), .SCROLL_X(SCROLL_X), .SCROLL_Y(SCROLL_Y),
        .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA), .VRAM_WE(VRAM_WE), .VRAM_RE(VRAM_RE),
        .VRAM_RDATA(VRAM_RDATA), .OAM_ADDR(OAM_ADDR), .OAM_WDATA(OAM_WDATA), .OAM_WE(OAM_WE),
        .OAM_RDATA(OAM_RDATA)
    );

    // Memories standing in for the renderer side.
    logic [7:0] vram_dev [0:16383];
    logic [7:0] oam_dev  [0:255];
    assign VRAM_RDATA = vram_dev[VRAM_ADDR];
    assign OAM_RDATA  = oam_dev[OAM_ADDR];
    always @(posedge PPU_SLOW_CLOCK) begin
        if (VRAM_WE) vram_dev[VRAM_ADDR] <= VRAM_WDATA;
        if (OAM_WE)  oam_dev[OAM_ADDR]   <= OAM_WDATA;
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model state.
    logic [7:0]  m_ctl, m_mask, m_oam_addr, m_sx, m_sy, m_rbuf, m_ob;
    logic [13:0] m_v, m_t;
    logic        m_w, m_vbl, m_spr0;
    logic [7:0]  m_vram [0:16383];
    logic [7:0]  m_oam  [0:255];

    // Expected events: {kind[1:0], addr[13:0], data[7:0]}; 0=VRAM write, 1=VRAM read, 2=OAM write, 3=CPU read data.
    logic [23:0] exp_q[$];

    function automatic void push(input logic [1:0] k, input logic [13:0] ad, input logic [7:0] dt);
        exp_q.push_back({k, ad, dt});
    endfunction

    task automatic model_reset();
        m_ctl = 0; m_mask = 0; m_oam_addr = 0; m_sx = 0; m_sy = 0; m_rbuf = 0; m_ob = 0;
        m_v = 0; m_t = 0; m_w = 0; m_vbl = 0; m_spr0 = 0;
    endtask

    task automatic model_access(input bit rw, input logic [2:0] a, input logic [7:0] d, input bit vs);
        logic [7:0] rd;
        if (!rw) begin
            m_ob = d;
            case (a)
                3'd0: m_ctl = d;
                3'd1: m_mask = d;
                3'd3: m_oam_addr = d;
                3'd4: begin push(2'd2, {6'd0, m_oam_addr}, d); m_oam[m_oam_addr] = d; m_oam_addr = m_oam_addr + 8'd1; end
                3'd5: begin if (!m_w) m_sx = d; else m_sy = d; m_w = !m_w; end
                3'd6: begin
                    if (!m_w) m_t = {d[5:0], m_t[7:0]};
                    else begin m_t = {m_t[13:8], d}; m_v = m_t; end
                    m_w = !m_w;
                end
                3'd7: begin push(2'd0, m_v, d); m_vram[m_v] = d; m_v = m_v + (m_ctl[2] ? 14'd32 : 14'd1); end
                default: ;
            endcase
            if (vs) m_vbl = 1'b1;
        end else begin
            case (a)
                3'd2: begin push(2'd3, 14'd0, {m_vbl & !vs, m_spr0, 1'b0, m_ob[4:0]}); m_vbl = 1'b0; m_w = 1'b0; end
                3'd4: push(2'd3, 14'd0, m_oam[m_oam_addr]);
                3'd7: begin
                    push(2'd1, m_v, 8'h00);
                    rd = m_rbuf;
`ifdef PPU_PALETTE_READ_BYPASS_EN
                    if (m_v >= PAL_BASE) rd = m_vram[m_v];
`endif
                    push(2'd3, 14'd0, rd);
                    m_rbuf = m_vram[m_v];
                    m_v = m_v + (m_ctl[2] ? 14'd32 : 14'd1);
                end
                default: push(2'd3, 14'd0, m_ob);
            endcase
            if (vs && a != 3'd2) m_vbl = 1'b1;
        end
    endtask

    task automatic cpu_access(input bit rw, input logic [2:0] a, input logic [7:0] d,
                              input int hold = 3, input bit vs = 1'b0);
        @(posedge PPU_SLOW_CLOCK); #1;
        cpu.CS = 1'b1; cpu.RW = rw; cpu.CPUA = a; cpu.CPUDI = d; VBL_SET = vs;
        model_access(rw, a, d, vs);
        @(posedge PPU_SLOW_CLOCK); #1;
        VBL_SET = 1'b0;
        repeat (hold - 1) @(posedge PPU_SLOW_CLOCK);
        #1 cpu.CS = 1'b0;
        repeat (2) @(posedge PPU_SLOW_CLOCK);
        #1;
    endtask

    task automatic flags(input bit vs, input bit vc, input bit ss);
        @(posedge PPU_SLOW_CLOCK); #1;
        VBL_SET = vs; VBL_CLR = vc; SPR0_SET = ss;
        if (vc) begin m_vbl = 1'b0; m_spr0 = 1'b0; end
        else begin if (vs) m_vbl = 1'b1; if (ss) m_spr0 = 1'b1; end
        @(posedge PPU_SLOW_CLOCK); #1;
        VBL_SET = 1'b0; VBL_CLR = 1'b0; SPR0_SET = 1'b0;
        @(posedge PPU_SLOW_CLOCK); #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " VRAM_ADDR"}, 32'(VRAM_ADDR), 32'(m_v));
        chk({tag, " OAM_ADDR"}, 32'(OAM_ADDR), 32'(m_oam_addr));
        chk({tag, " PPUCTL"}, 32'(PPUCTL_O), 32'(m_ctl));
        chk({tag, " PPUMASK"}, 32'(PPUMASK_O), 32'(m_mask));
        chk({tag, " SCROLL_X"}, 32'(SCROLL_X), 32'(m_sx));
        chk({tag, " SCROLL_Y"}, 32'(SCROLL_Y), 32'(m_sy));
        chk({tag, " NMI"}, 32'(NMI), 32'(m_vbl & m_ctl[7]));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or completes a CPU read.
    bit mon_en = 1'b0;
    logic cs_seen = 1'b0, rw_seen = 1'b0;

    task automatic check_ev(input string nm, input logic [23:0] act);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL %s unexpected event: got %0h expected none", nm, act);
        end else begin
            e = exp_q.pop_front();
            chk(nm, 32'(act), 32'(e));
        end
    endtask

    always @(negedge PPU_SLOW_CLOCK) begin
        if (mon_en) begin
            if (VRAM_WE) check_ev("vram_we", {2'd0, VRAM_ADDR, VRAM_WDATA});
            if (VRAM_RE) check_ev("vram_re", {2'd1, VRAM_ADDR, 8'h00});
            if (OAM_WE)  check_ev("oam_we",  {2'd2, 6'd0, OAM_ADDR, OAM_WDATA});
            if (cs_seen && !cpu.CS && rw_seen) check_ev("cpudo", {2'd3, 14'd0, cpu.CPUDO});
        end
        cs_seen = cpu.CS;
        rw_seen = cpu.RW;
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin vram_dev[i] = 8'($urandom); m_vram[i] = vram_dev[i]; end
        for (int i = 0; i < 256; i++)   begin oam_dev[i]  = 8'($urandom); m_oam[i]  = oam_dev[i];  end
        cpu.CS = 0; cpu.RW = 0; cpu.CPUA = 0; cpu.CPUDI = 0;
        VBL_SET = 0; VBL_CLR = 0; SPR0_SET = 0;
        RST = 1'b1;
        model_reset();
        repeat (3) @(posedge PPU_SLOW_CLOCK);
        #1;
        chk("reset CPUDO", 32'(cpu.CPUDO), 0);
        chk("reset NMI", 32'(NMI), 0);
        chk("reset VRAM_WE", 32'(VRAM_WE), 0);
        chk("reset VRAM_RE", 32'(VRAM_RE), 0);
        chk("reset OAM_WE", 32'(OAM_WE), 0);
        chk("reset VRAM_ADDR", 32'(VRAM_ADDR), 0);
        chk("reset PPUCTL", 32'(PPUCTL_O), 0);
        chk("reset OAM_ADDR", 32'(OAM_ADDR), 0);
        RST = 1'b0;
        mon_en = 1'b1;

        // VRAM write through $2006/$2007
        cpu_access(0, 3'd6, 8'h21);
        cpu_access(0, 3'd6, 8'h08);
        cpu_access(0, 3'd7, 8'h5A);
        chk("v after write", 32'(VRAM_ADDR), 32'h2109);

        // Buffered reads with +32 increment
        vram_dev[14'h23FF] = 8'h11; m_vram[14'h23FF] = 8'h11;
        vram_dev[14'h241F] = 8'h22; m_vram[14'h241F] = 8'h22;
        cpu_access(0, 3'd0, 8'h04);
        cpu_access(0, 3'd6, 8'h23);
        cpu_access(0, 3'd6, 8'hFF);
        cpu_access(1, 3'd7, 8'h00);
        chk("first buffered read", 32'(cpu.CPUDO), 32'h00);
        cpu_access(1, 3'd7, 8'h00);
        chk("second buffered read", 32'(cpu.CPUDO), 32'h11);
        chk("v after reads", 32'(VRAM_ADDR), 32'h243F);

        // NMI from vblank
        cpu_access(0, 3'd0, 8'h80);
        flags(1, 0, 0);
        chk("nmi raised", 32'(NMI), 1);
        cpu_access(1, 3'd2, 8'h00);
        chk("status bit7 set", 32'(cpu.CPUDO[7]), 1);
        chk("nmi dropped", 32'(NMI), 0);
        cpu_access(1, 3'd2, 8'h00);
        chk("status bit7 cleared", 32'(cpu.CPUDO[7]), 0);

        // Status read coincident with VBL_SET suppresses the flag
        cpu_access(1, 3'd2, 8'h00, 3, 1'b1);
        chk("suppressed bit7", 32'(cpu.CPUDO[7]), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge PPU_SLOW_CLOCK); #1;
            chk("nmi stays low", 32'(NMI), 0);
        end
        check_state("suppress");

        // OAMADDR wrap
        cpu_access(0, 3'd3, 8'hFF);
        cpu_access(0, 3'd4, 8'hAA);
        cpu_access(0, 3'd4, 8'hBB);
        chk("oam addr wrap", 32'(OAM_ADDR), 32'h01);

        // Scroll latch with w reset by status read; then a long CS hold
        cpu_access(0, 3'd5, 8'h10);
        cpu_access(1, 3'd2, 8'h00);
        cpu_access(0, 3'd5, 8'h20);
        chk("scroll x", 32'(SCROLL_X), 32'h20);
        chk("scroll y", 32'(SCROLL_Y), 32'h00);
        cpu_access(0, 3'd7, 8'h3C, 10);
        check_state("long hold");

        // Reset in the middle of a $2007 write
        @(posedge PPU_SLOW_CLOCK); #1;
        cpu.CS = 1'b1; cpu.RW = 1'b0; cpu.CPUA = 3'd7; cpu.CPUDI = 8'h77;
        @(posedge PPU_SLOW_CLOCK); #1;
        chk("strobe before reset", 32'(VRAM_WE), 1);
        RST = 1'b1;
        #1;
        chk("strobe dropped by reset", 32'(VRAM_WE), 0);
        @(posedge PPU_SLOW_CLOCK);
        @(posedge PPU_SLOW_CLOCK); #1;
        RST = 1'b0;
        model_reset();
        repeat (4) @(posedge PPU_SLOW_CLOCK);
        #1 cpu.CS = 1'b0;
        repeat (2) @(posedge PPU_SLOW_CLOCK);
        #1;
        check_state("after mid reset");

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                flags(bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, bit'($urandom_range(0, 1)));
            end else begin
                cpu_access(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                           $urandom_range(3, 5), $urandom_range(0, 7) == 0);
            end
            check_state("random");
        end

        repeat (4) @(posedge PPU_SLOW_CLOCK);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
